// File: rtl/accum4_seq_pkg.sv
// Shared constants for the accumulator stage: data width common with radd
// and the FSM state encoding (code 2'd3 is unused and recovers to IDLE).
package accum4_seq_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/accum4_seq_radd.sv
// radd: 4-bit ripple-carry adder, sum modulo 2^DATA_W, no carry-out port.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module radd
    import accum4_seq_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    output logic [DATA_W-1:0] s
);

    logic [DATA_W:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < DATA_W; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    // The top bit's carry is deliberately dropped; callers detect wrap themselves.
    logic unused_carry;
    assign unused_carry = c[DATA_W];

endmodule

// File: rtl/accum4_seq.sv
// accum4_seq: sums a batch of NUM_OPS 4-bit operands via radd, reports sum mod 16 and a sticky carry flag.
// Latency: out_valid rises on the edge accepting the last operand; batch takes >= NUM_OPS+2 cycles.
// Backpressure: in_ready only in ACCUM; the result holds in DONE until out_ready.
module accum4_seq
    import accum4_seq_pkg::*;
#(
    parameter int NUM_OPS = 4,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_ovf,
    input  logic              out_ready,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OPS - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] s;
    logic              carry;

    radd u_radd (
        .x (acc_q),
        .y (in_data),
        .s (s)
    );

    // Without a carry-out, a wrapped sum is the only case where s drops below acc.
    assign carry = (s < acc_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = s;
                    ovf_d = ovf_q | carry;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;

endmodule
